// File: rtl/mips_boot_pkg.sv
// Shared state encoding and default parameters for the MIPS boot/run controller.
package mips_boot_pkg;

    localparam int unsigned DEF_ADDR_W     = 10;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_RST_CYCLES = 4;
    localparam int unsigned DEF_CNT_W      = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RESET = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } boot_state_t;

endpackage

// File: rtl/boot_rst_stretch.sv
// Load-and-count-down counter that times the CPU reset stretch.
module boot_rst_stretch #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/mips_boot_ctrl.sv
// Boot/run controller: streams an image into instruction memory, stretches CPU reset,
// then supervises the run. Optional load checksum enabled by BOOT_CHECKSUM_EN.
module mips_boot_ctrl
    import mips_boot_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_rst,
    input  logic [31:0]       pc,
    input  logic [31:0]       halt_pc,
    input  logic [CNT_W-1:0]  timeout,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic              ovf,
    output logic [ADDR_W:0]   word_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [31:0]       checksum
);

    // Stretch counter is loaded with RST_CYCLES-1 so RUN starts RST_CYCLES edges after the last write.
    localparam int unsigned SW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(RST_CYCLES - 1);

    boot_state_t state;
    logic        accept;
    logic        load_end;
    logic        stretch_expired;

    assign ld_ready = (state == LOAD);
    assign busy     = (state == LOAD) || (state == RESET) || (state == RUN);
    assign done     = (state == DONE);
    assign accept   = ld_valid && ld_ready;
    assign load_end = accept && (ld_last || (&word_count[ADDR_W-1:0]));

    boot_rst_stretch #(.W(SW)) u_stretch (
        .clk      (clk),
        .rst      (rst),
        .load     (load_end),
        .load_val (STRETCH_LOAD),
        .expired  (stretch_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cpu_rst     <= 1'b1;
            im_we       <= 1'b0;
            im_addr     <= '0;
            im_wdata    <= '0;
            word_count  <= '0;
            cycle_count <= '0;
            timed_out   <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            im_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= LOAD;
                        word_count  <= '0;
                        cycle_count <= '0;
                        timed_out   <= 1'b0;
                        ovf         <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        im_we      <= 1'b1;
                        im_addr    <= word_count[ADDR_W-1:0];
                        im_wdata   <= ld_data;
                        word_count <= word_count + 1'b1;
                        if (ld_last) begin
                            state <= RESET;
                        end else if (&word_count[ADDR_W-1:0]) begin
                            ovf   <= 1'b1;
                            state <= RESET;
                        end
                    end
                end
                RESET: begin
                    if (stretch_expired) begin
                        state   <= RUN;
                        cpu_rst <= 1'b0;
                    end
                end
                RUN: begin
                    // Halt takes priority over the budget; the exit edge does not count a cycle.
                    if (pc == halt_pc) begin
                        state   <= DONE;
                        cpu_rst <= 1'b1;
                    end else if ((timeout != '0) && (cycle_count == timeout - 1'b1)) begin
                        state     <= DONE;
                        cpu_rst   <= 1'b1;
                        timed_out <= 1'b1;
                    end else if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cpu_rst <= 1'b1;
                end
            endcase
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (((state == IDLE) || (state == DONE)) && start) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + 32'(ld_data);
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Scoreboard bench for mips_boot_ctrl, built with a 4-word memory to reach the overflow path.
module tb_mips_boot_ctrl;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned RC = 4;
    localparam int unsigned CW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [DW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_wdata;
    logic          cpu_rst;
    logic [31:0]   pc = '0;
    logic [31:0]   halt_pc = '0;
    logic [CW-1:0] timeout = '0;
    logic          busy;
    logic          done;
    logic          timed_out;
    logic          ovf;
    logic [AW:0]   word_count;
    logic [CW-1:0] cycle_count;
    logic [31:0]   checksum;

    mips_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RST_CYCLES(RC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .cpu_rst(cpu_rst), .pc(pc), .halt_pc(halt_pc),
        .timeout(timeout), .busy(busy), .done(done), .timed_out(timed_out), .ovf(ovf),
        .word_count(word_count), .cycle_count(cycle_count), .checksum(checksum)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [AW+DW-1:0] sb[$];
    int unsigned exp_addr = 0;
    logic [31:0] exp_sum = '0;
    int nwrites = 0;

    function automatic logic [31:0] exp_cs();
`ifdef BOOT_CHECKSUM_EN
        return exp_sum;
`else
        return '0;
`endif
    endfunction

    // Every memory write must match the oldest word the bench saw accepted.
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        if (im_we === 1'b1) begin
            checks++;
            nwrites++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL im_write unexpected: addr=%0d data=%h, none required", im_addr, im_wdata);
            end else begin
                e = sb.pop_front();
                if ({im_addr, im_wdata} !== e) begin
                    failures++;
                    $display("FAIL im_write got addr=%0d data=%h required addr=%0d data=%h",
                             im_addr, im_wdata, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr = 0;
        exp_sum = '0;
        nwrites = 0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        bit ok = 1'b0;
        ld_valid = 1'b1;
        ld_data = d;
        ld_last = last;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (ld_ready === 1'b1) begin
                sb.push_back({exp_addr[AW-1:0], d});
                exp_addr++;
                exp_sum += d;
                ok = 1'b1;
            end
            @(negedge clk);
        end
        ld_valid = 1'b0;
        ld_last = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_wait got no acceptance required acceptance of %h", d);
        end
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (cpu_rst !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_wait got done=%b required 1", done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({cpu_rst, ld_ready, im_we, done, timed_out, ovf, busy} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_flags got %b required 1000000",
                     {cpu_rst, ld_ready, im_we, done, timed_out, ovf, busy});
        end
        checks++;
        if ({im_addr, im_wdata, word_count, cycle_count, checksum} !== '0) begin
            failures++;
            $display("FAIL reset_values got addr=%0d wdata=%h wc=%0d cc=%0d cs=%h required all 0",
                     im_addr, im_wdata, word_count, cycle_count, checksum);
        end
    endtask

    task automatic test_load_run();
        int n;
        timeout = '0;
        halt_pc = 32'h0000_300C;
        pc = '0;
        do_start();
        checks++;
        if (ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_to_ready got %b required 1", ld_ready);
        end
        send_word(32'h2008_0005, 1'b0);
        send_word(32'h2009_0003, 1'b0);
        send_word(32'h0109_5020, 1'b1);
        checks++;
        if (word_count !== 3'd3 || busy !== 1'b1 || cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL load_end got wc=%0d busy=%b cpu_rst=%b required 3 1 1", word_count, busy, cpu_rst);
        end
        wait_run(n);
        checks++;
        if (n != int'(RC)) begin
            failures++;
            $display("FAIL rst_stretch got %0d cycles required %0d", n, RC);
        end
        checks++;
        if (nwrites != 3) begin
            failures++;
            $display("FAIL write_count got %0d required 3", nwrites);
        end
        checks++;
        if (checksum !== exp_cs()) begin
            failures++;
            $display("FAIL checksum_prog got %h required %h", checksum, exp_cs());
        end
        repeat (6) @(negedge clk);
        pc = 32'h0000_300C;
        @(negedge clk);
        checks++;
        if ({done, timed_out, cpu_rst, busy} !== 4'b1010 || cycle_count !== 24'd6) begin
            failures++;
            $display("FAIL halt got done=%b to=%b cpu_rst=%b busy=%b cc=%0d required 1 0 1 0 6",
                     done, timed_out, cpu_rst, busy, cycle_count);
        end
        pc = '0;
    endtask

    task automatic test_timeout();
        int n;
        bit low_ok = 1'b1;
        halt_pc = 32'hFFFF_FFF0;
        pc = '0;
        timeout = 24'd10;
        do_start();
        send_word(32'h1234_5678, 1'b1);
        wait_run(n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (cpu_rst !== 1'b0) low_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 10 || timed_out !== 1'b1 || !low_ok) begin
            failures++;
            $display("FAIL timeout got cycles=%0d to=%b cpu_rst_low=%0d required 10 1 1", n, timed_out, low_ok);
        end

        halt_pc = 32'h0000_300C;
        do_start();
        send_word(32'h8765_4321, 1'b1);
        wait_run(n);
        repeat (9) @(negedge clk);
        pc = 32'h0000_300C;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || timed_out !== 1'b0 || cycle_count !== 24'd9) begin
            failures++;
            $display("FAIL halt_vs_timeout got done=%b to=%b cc=%0d required 1 0 9", done, timed_out, cycle_count);
        end
        pc = '0;
        timeout = '0;
    endtask

    task automatic test_overflow();
        int n;
        int acc = 0;
        halt_pc = '0;
        pc = '0;
        do_start();
        ld_valid = 1'b1;
        for (int i = 0; i < 10 && acc < 6; i++) begin
            ld_data = 32'hA000_0000 + acc;
            if (ld_ready === 1'b1) begin
                sb.push_back({exp_addr[AW-1:0], ld_data});
                exp_addr++;
                acc++;
            end
            @(negedge clk);
        end
        ld_valid = 1'b0;
        checks++;
        if (acc != 4 || ovf !== 1'b1 || ld_ready !== 1'b0 || word_count !== 3'd4) begin
            failures++;
            $display("FAIL overflow got acc=%0d ovf=%b ready=%b wc=%0d required 4 1 0 4", acc, ovf, ld_ready, word_count);
        end
        wait_done(n);
    endtask

    task automatic test_rst_mid_load();
        int n;
        halt_pc = '0;
        pc = '0;
        do_start();
        send_word(32'h1111_1111, 1'b0);
        send_word(32'h2222_2222, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({cpu_rst, ld_ready, im_we, done, timed_out, ovf, busy} !== 7'b1000000 ||
            {im_addr, im_wdata, word_count, cycle_count, checksum} !== '0) begin
            failures++;
            $display("FAIL mid_load_rst got flags=%b wc=%0d addr=%0d cs=%h required 1000000 0 0 0",
                     {cpu_rst, ld_ready, im_we, done, timed_out, ovf, busy}, word_count, im_addr, checksum);
        end
        do_start();
        send_word(32'h3333_3333, 1'b1);
        wait_done(n);
        checks++;
        if (word_count !== 3'd1) begin
            failures++;
            $display("FAIL restart_count got %0d required 1", word_count);
        end
    endtask

    task automatic test_checksum();
        int n;
        halt_pc = '0;
        pc = '0;
        do_start();
        send_word(32'hFFFF_FFFF, 1'b0);
        send_word(32'h0000_0002, 1'b1);
        checks++;
        if (checksum !== exp_cs()) begin
            failures++;
            $display("FAIL checksum_wrap got %h required %h", checksum, exp_cs());
        end
        wait_done(n);
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_timeout();
        test_overflow();
        test_rst_mid_load();
        test_checksum();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
